// File: rtl/ccd_line_framer.sv
`default_nettype none
// ============================================================================
// Module   : ccd_line_framer
// Brief    : Strips lead/overscan pixels of each CCD line and frames the active
//            pixels (SOL/EOL) into a small backpressure FIFO.
//            Optional DARK_SUB_EN: optical-black average subtracted from pixels.
// Revision : 1.0 - initial release
// ============================================================================
module ccd_line_framer #(
    parameter int LEAD_PIX   = 32,
    parameter int DARK_START = 16,
    parameter int DARK_LOG2  = 3,
    parameter int ACTIVE_PIX = 2048,
    parameter int FIFO_LOG2  = 3
) (
    input  logic        clk_80M,
    input  logic        rst_n,
    input  logic        en,
    input  logic        line_start,
    input  logic        pix_clk,
    input  logic [15:0] pix_data,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic        ovf,
    output logic        short_line,
    input  logic        clr_status
);

    localparam int c_DARK_N   = 2 ** DARK_LOG2;
    localparam int c_SPAN0    = (LEAD_PIX > ACTIVE_PIX) ? LEAD_PIX : ACTIVE_PIX;
    localparam int c_SPAN     = (c_SPAN0 > DARK_START + c_DARK_N) ? c_SPAN0 : DARK_START + c_DARK_N;
    localparam int c_CNT_W    = ($clog2(c_SPAN) > 12) ? $clog2(c_SPAN) : 12;
    localparam int c_DEPTH    = 2 ** FIFO_LOG2;
    localparam int c_FIFO_CW  = FIFO_LOG2 + 1;

    localparam logic [c_CNT_W-1:0]   c_LEAD_LAST  = c_CNT_W'(LEAD_PIX - 1);
    localparam logic [c_CNT_W-1:0]   c_ACT_LAST   = c_CNT_W'(ACTIVE_PIX - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_FIFO_CW-1:0] c_DEPTH_CNT  = c_FIFO_CW'(c_DEPTH);
    localparam logic [c_FIFO_CW-1:0] c_FIFO_ONE   = c_FIFO_CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEAD   = 2'd1,
        S_ACTIVE = 2'd2,
        S_TAIL   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_pix_cnt;
    logic [c_CNT_W-1:0]   w_pix_cnt_next;
    logic                 r_pix_clk_d;
    logic                 w_pix_edge;
    logic                 w_cap_en;
    logic                 w_cap_user;
    logic                 w_cap_last;
    logic                 w_set_short;
    logic                 w_lead_done;
    logic [15:0]          w_pix_proc;

    assign w_pix_edge = pix_clk & ~r_pix_clk_d;

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_pix_clk_d <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pix_cnt   <= w_pix_cnt_next;
            r_pix_clk_d <= pix_clk;
        end
    end

    // line_start always wins; a strobe in the same cycle is discarded
    always_comb begin
        w_state_next   = r_state;
        w_pix_cnt_next = r_pix_cnt;
        w_cap_en       = 1'b0;
        w_cap_user     = 1'b0;
        w_cap_last     = 1'b0;
        w_set_short    = 1'b0;
        w_lead_done    = 1'b0;
        if (line_start) begin
            w_pix_cnt_next = '0;
            case (r_state)
                S_LEAD:   w_state_next = S_LEAD;
                S_ACTIVE: begin
                    w_state_next = S_LEAD;
                    w_set_short  = 1'b1;
                end
                default:  w_state_next = en ? S_LEAD : S_IDLE;
            endcase
        end else if (w_pix_edge) begin
            case (r_state)
                S_LEAD: begin
                    if (r_pix_cnt == c_LEAD_LAST) begin
                        w_state_next   = S_ACTIVE;
                        w_pix_cnt_next = '0;
                        w_lead_done    = 1'b1;
                    end else begin
                        w_pix_cnt_next = r_pix_cnt + c_CNT_ONE;
                    end
                end
                S_ACTIVE: begin
                    w_cap_en   = 1'b1;
                    w_cap_user = (r_pix_cnt == '0);
                    w_cap_last = (r_pix_cnt == c_ACT_LAST);
                    if (w_cap_last) begin
                        w_state_next   = S_TAIL;
                        w_pix_cnt_next = '0;
                    end else begin
                        w_pix_cnt_next = r_pix_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DARK_SUB_EN
    localparam int                 c_SUM_W      = 16 + DARK_LOG2;
    localparam logic [c_CNT_W-1:0] c_DARK_FIRST = c_CNT_W'(DARK_START);
    localparam logic [c_CNT_W-1:0] c_DARK_CNT   = c_CNT_W'(c_DARK_N);

    logic [c_SUM_W-1:0] r_dark_sum;
    logic [c_SUM_W-1:0] w_dark_sum_next;
    logic [15:0]        r_dark;
    logic [c_CNT_W-1:0] w_dark_off;
    logic               w_in_dark;

    // indices below DARK_START wrap to large offsets, so one compare bounds the window
    assign w_dark_off      = r_pix_cnt - c_DARK_FIRST;
    assign w_in_dark       = (r_state == S_LEAD) && w_pix_edge && !line_start && (w_dark_off < c_DARK_CNT);
    assign w_dark_sum_next = r_dark_sum + (w_in_dark ? c_SUM_W'(pix_data) : '0);

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            r_dark_sum <= '0;
            r_dark     <= '0;
        end else begin
            if (line_start) begin
                r_dark_sum <= '0;
            end else if (w_in_dark) begin
                r_dark_sum <= w_dark_sum_next;
            end
            if (w_lead_done) begin
                r_dark <= w_dark_sum_next[c_SUM_W-1:DARK_LOG2];
            end
        end
    end

    assign w_pix_proc = (pix_data > r_dark) ? (pix_data - r_dark) : 16'd0;
`else
    assign w_pix_proc = pix_data;
`endif

    logic        r_cap_valid;
    logic        r_cap_user;
    logic        r_cap_last;
    logic [15:0] r_cap_data;

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_user  <= 1'b0;
            r_cap_last  <= 1'b0;
            r_cap_data  <= '0;
        end else begin
            r_cap_valid <= w_cap_en;
            if (w_cap_en) begin
                r_cap_user <= w_cap_user;
                r_cap_last <= w_cap_last;
                r_cap_data <= w_pix_proc;
            end
        end
    end

    logic [17:0]          r_mem [c_DEPTH];
    logic [FIFO_LOG2-1:0] r_wr_ptr;
    logic [FIFO_LOG2-1:0] r_rd_ptr;
    logic [c_FIFO_CW-1:0] r_count;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [17:0]          w_head;

    assign w_full   = (r_count == c_DEPTH_CNT);
    assign m_tvalid = (r_count != '0);
    assign w_pop    = m_tvalid & m_tready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push   = r_cap_valid & (~w_full | w_pop);
    assign w_drop   = r_cap_valid & w_full & ~w_pop;
    assign w_head   = m_tvalid ? r_mem[r_rd_ptr] : 18'd0;

    assign m_tuser  = w_head[17];
    assign m_tlast  = w_head[16];
    assign m_tdata  = w_head[15:0];

    always_ff @(posedge clk_80M) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_cap_user, r_cap_last, r_cap_data};
        end
    end

    always_ff @(posedge clk_80M or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            ovf        <= 1'b0;
            short_line <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FIFO_ONE;
                2'b01:   r_count <= r_count - c_FIFO_ONE;
                default: ;
            endcase
            ovf        <= (ovf & ~clr_status) | w_drop;
            short_line <= (short_line & ~clr_status) | w_set_short;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccd_line_framer.sv
`default_nettype none
// Random CCD lines checked against a line-level reference model through an output scoreboard.
module tb_ccd_line_framer;

    localparam int LEAD_PIX   = 6;
    localparam int DARK_START = 1;
    localparam int DARK_LOG2  = 2;
    localparam int ACTIVE_PIX = 10;
    localparam int FIFO_LOG2  = 2;
    localparam int DARK_N     = 1 << DARK_LOG2;
    localparam int DEPTH      = 1 << FIFO_LOG2;
    localparam int FULL_LINE  = LEAD_PIX + ACTIVE_PIX;
`ifdef DARK_SUB_EN
    localparam bit DARK_EN = 1'b1;
`else
    localparam bit DARK_EN = 1'b0;
`endif

    logic        clk_80M    = 1'b0;
    logic        rst_n      = 1'b0;
    logic        en         = 1'b0;
    logic        line_start = 1'b0;
    logic        pix_clk    = 1'b0;
    logic [15:0] pix_data   = 16'd0;
    logic        m_tready   = 1'b0;
    logic        clr_status = 1'b0;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tuser;
    logic        m_tlast;
    logic        ovf;
    logic        short_line;

    ccd_line_framer #(
        .LEAD_PIX   (LEAD_PIX),
        .DARK_START (DARK_START),
        .DARK_LOG2  (DARK_LOG2),
        .ACTIVE_PIX (ACTIVE_PIX),
        .FIFO_LOG2  (FIFO_LOG2)
    ) dut (
        .clk_80M    (clk_80M),
        .rst_n      (rst_n),
        .en         (en),
        .line_start (line_start),
        .pix_clk    (pix_clk),
        .pix_data   (pix_data),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tuser    (m_tuser),
        .m_tlast    (m_tlast),
        .ovf        (ovf),
        .short_line (short_line),
        .clr_status (clr_status)
    );

    always #5 clk_80M = ~clk_80M;

    logic [17:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_mode = 2;   // 0: random, never low 3 cycles running; 1: held low; 2: held high
    int          low_run  = 0;

    // reference model state, per line rather than per cycle
    bit          in_line       = 1'b0;
    bit          pending_short = 1'b0;
    bit          short_m       = 1'b0;
    logic [15:0] dark_m        = 16'd0;

    task automatic tick();
        @(posedge clk_80M);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] proc(input logic [15:0] s);
        if (!DARK_EN) return s;
        return (s > dark_m) ? 16'(s - dark_m) : 16'd0;
    endfunction

    initial begin
        forever begin
            @(posedge clk_80M);
            #1;
            case (rdy_mode)
                1:       m_tready = 1'b0;
                2:       m_tready = 1'b1;
                default: begin
                    m_tready = (low_run >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
                    low_run  = m_tready ? 0 : low_run + 1;
                end
            endcase
        end
    end

    always @(negedge clk_80M) begin
        logic [17:0] e;
        if (rst_n && m_tvalid && m_tready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got user=%0b last=%0b data=%0d, required no output",
                         m_tuser, m_tlast, m_tdata);
            end else begin
                e = sb_q.pop_front();
                if ({m_tuser, m_tlast, m_tdata} !== e) begin
                    n_fail++;
                    $display("FAIL out_pixel: got user=%0b last=%0b data=%0d, required user=%0b last=%0b data=%0d",
                             m_tuser, m_tlast, m_tdata, e[17], e[16], e[15:0]);
                end
            end
        end
    end

    task automatic pixel(input logic [15:0] d, input bit with_ls);
        pix_data   = d;
        pix_clk    = 1'b1;
        line_start = with_ls;
        tick();
        line_start = 1'b0;
        tick();
        pix_clk = 1'b0;
        repeat ($urandom_range(2, 3)) tick();
    endtask

    task automatic pulse_ls();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
    endtask

    // n samples after line_start; cap = active pixels the FIFO can take; en drops after sample en_drop_at
    task automatic run_line(input int n, input bit coinc, input int en_drop_at, input int cap);
        bit          framed;
        int          sum;
        int          j;
        logic [15:0] s;
        framed = in_line || en;
        if (pending_short) short_m = 1'b1;
        pending_short = 1'b0;
        if (coinc) pixel(16'($urandom), 1'b1);
        else       pulse_ls();
        sum = 0;
        for (int i = 0; i < n; i++) begin
            s = 16'($urandom);
            if (framed) begin
                if (i >= DARK_START && i < DARK_START + DARK_N) sum += int'(s);
                if (i == LEAD_PIX - 1) dark_m = 16'(sum >> DARK_LOG2);
                j = i - LEAD_PIX;
                if (j >= 0 && j < ACTIVE_PIX && j < cap)
                    sb_q.push_back({j == 0, j == ACTIVE_PIX - 1, proc(s)});
            end
            pixel(s, 1'b0);
            if (i == en_drop_at) en = 1'b0;
        end
        if (framed) begin
            in_line       = (n < FULL_LINE);
            pending_short = (n >= LEAD_PIX) && in_line;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        rdy_mode = 2;
        while ((sb_q.size() != 0 || m_tvalid) && t < 300) begin
            tick();
            t++;
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        tick();
    endtask

    initial begin
        int sel;
        int n;
        repeat (3) tick();
        check("reset_outputs", {m_tvalid, m_tuser, m_tlast, ovf, short_line, m_tdata}, 0);
        rst_n = 1'b1;
        tick();
        en = 1'b1;

        // clean lines, including a strobe coincident with line_start
        rdy_mode = 2;
        run_line(FULL_LINE + 2, 1'b0, -1, ACTIVE_PIX);
        run_line(FULL_LINE + 2, 1'b1, -1, ACTIVE_PIX);
        drain();
        check("ovf_clean", ovf, 0);
        check("short_clean", short_line, 0);

        // truncated line then a full one
        run_line(LEAD_PIX + 3, 1'b0, -1, ACTIVE_PIX);
        run_line(FULL_LINE, 1'b0, -1, ACTIVE_PIX);
        drain();
        check("short_set", short_line, short_m);
        pulse_clr();
        short_m = 1'b0;
        check("short_cleared", short_line, 0);

        // randomized lines under bounded backpressure
        rdy_mode = 0;
        for (int k = 0; k < 30; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)      n = FULL_LINE + $urandom_range(0, 3);
            else if (sel < 9) n = LEAD_PIX + $urandom_range(0, ACTIVE_PIX - 1);
            else              n = $urandom_range(0, LEAD_PIX - 1);
            run_line(n, $urandom_range(0, 3) == 0, -1, ACTIVE_PIX);
        end
        run_line(FULL_LINE, 1'b0, -1, ACTIVE_PIX);
        drain();
        check("short_random", short_line, short_m);
        check("ovf_random", ovf, 0);
        pulse_clr();
        short_m = 1'b0;

        // en drops mid-line: line completes, next line ignored
        run_line(FULL_LINE, 1'b0, 3, ACTIVE_PIX);
        run_line(FULL_LINE, 1'b0, -1, ACTIVE_PIX);
        drain();
        check("en_off_idle", m_tvalid, 0);
        en = 1'b1;

        // overflow with the sink stalled
        rdy_mode = 1;
        run_line(FULL_LINE, 1'b0, -1, DEPTH);
        check("ovf_set", ovf, 1);
        drain();
        check("ovf_sticky", ovf, 1);
        pulse_clr();
        check("ovf_cleared", ovf, 0);

        // asynchronous reset with FIFO occupied mid-ACTIVE
        rdy_mode = 1;
        run_line(LEAD_PIX + 2, 1'b0, -1, ACTIVE_PIX);
        check("fifo_occupied", m_tvalid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {m_tvalid, m_tuser, m_tlast, ovf, short_line, m_tdata}, 0);
        sb_q.delete();
        in_line       = 1'b0;
        pending_short = 1'b0;
        short_m       = 1'b0;
        dark_m        = 16'd0;
        tick();
        rst_n    = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) pixel(16'($urandom), 1'b0);
        check("no_restart_without_line_start", m_tvalid, 0);
        run_line(FULL_LINE + 1, 1'b0, -1, ACTIVE_PIX);
        drain();
        check("short_after_reset", short_line, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
